// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock's keypad and display scan paths.
// Key codes follow the physical keypad layout: code = row*4 + col.
package clock_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } scan_state_e;

  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_A    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_B    = 4'd7;
  localparam logic [3:0] KEY_7    = 4'd8;
  localparam logic [3:0] KEY_8    = 4'd9;
  localparam logic [3:0] KEY_9    = 4'd10;
  localparam logic [3:0] KEY_C    = 4'd11;
  localparam logic [3:0] KEY_STAR = 4'd12;
  localparam logic [3:0] KEY_0    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_D    = 4'd15;

  // Rows are active-low; the lowest-numbered low row wins.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
// Shared by the keypad scan and the seven-segment display scan.
module scan_tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: SCAN rotates columns | PRESS_DB confirms a press |
// PRESSED waits for all rows high | REL_DB confirms the release.
module keypad_scanner
  import clock_pkg::*;
#(
  parameter int CLK_DIV  = 50000,
  parameter int DB_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_release
);

  localparam int DBW = $clog2(DB_TICKS + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);

  logic        tick;
  logic [3:0]  row_meta_q, rs_q;
  scan_state_e state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [1:0]  cand_row_q, cand_row_d;
  logic [1:0]  cand_col_q, cand_col_d;
  logic [DBW-1:0] db_q, db_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic        rel_q, rel_d;
  logic        all_high;

  scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign all_high = &rs_q;

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    db_d       = db_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    held_d     = held_q;
    rel_d      = 1'b0;
    case (state_q)
      SCAN: if (tick) begin
        if (all_high) begin
          col_d = col_q + 2'd1;
        end else begin
          cand_row_d = lowest_low_row(rs_q);
          cand_col_d = col_q;
          db_d       = DBW'(1);
          state_d    = PRESS_DB;
        end
      end
      PRESS_DB: if (tick) begin
        if (!rs_q[cand_row_q]) begin
          if (db_q >= DB_LAST) begin
            state_d = PRESSED;
            code_d  = {cand_row_q, cand_col_q};
            valid_d = 1'b1;
            held_d  = 1'b1;
          end else begin
            db_d = db_q + DBW'(1);
          end
        end else begin
          state_d = SCAN;
        end
      end
      PRESSED: if (tick && all_high) begin
        db_d    = DBW'(1);
        state_d = REL_DB;
      end
      REL_DB: if (tick) begin
        if (all_high) begin
          if (db_q >= DB_LAST) begin
            rel_d   = 1'b1;
            held_d  = 1'b0;
            state_d = SCAN;
          end else begin
            db_d = db_q + DBW'(1);
          end
        end else begin
          state_d = PRESSED;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
      state_q    <= SCAN;
      col_q      <= 2'd0;
      cand_row_q <= 2'd0;
      cand_col_q <= 2'd0;
      db_q       <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      rel_q      <= 1'b0;
    end else begin
      row_meta_q <= row_in;
      rs_q       <= row_meta_q;
      state_q    <= state_d;
      col_q      <= col_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      db_q       <= db_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      rel_q      <= rel_d;
    end
  end

  assign col_out     = ~(4'b0001 << col_q);
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign key_release = rel_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a keypad model drives the rows from col_out; checks come from
// key-position arithmetic and scan-timing formulas, plus randomized press/release rounds.
module tb_keypad_scanner;

  localparam int CLK_DIV  = 4;
  localparam int DB_TICKS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_held, key_release;
  logic [15:0] keys;

  int n_pass = 0, n_chk = 0;
  int n_valid = 0, n_rel = 0, cyc = 0, valid_cyc = -1;

  always #5 clk = ~clk;

  keypad_scanner #(.CLK_DIV(CLK_DIV), .DB_TICKS(DB_TICKS)) dut (
    .clk         (clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_out     (col_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  // Keypad physics: a row reads low if any pressed key on it sits on a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
  end

  always @(posedge clk) begin
    #1;
    if (rst) cyc = 0;
    else     cyc++;
    if (key_valid) begin
      n_valid++;
      valid_cyc = cyc;
    end
    if (key_release) n_rel++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int exp_code(input int rmask, input int c);
    for (int r = 0; r < 4; r++) if (rmask[r]) return r * 4 + c;
    return -1;
  endfunction

  // Key pressed from reset release: first sample at the tick ending column c's slot.
  function automatic int exp_accept_cyc(input int c);
    return (c + DB_TICKS) * CLK_DIV;
  endfunction

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  function automatic logic [15:0] keys_for(input int rmask, input int c);
    logic [15:0] k;
    k = '0;
    for (int r = 0; r < 4; r++) if (rmask[r]) k[r*4 + c] = 1'b1;
    return k;
  endfunction

  task automatic wait_valid(input int prev, input string tag);
    int k = 0;
    while (n_valid == prev && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, n_valid, prev + 1);
  endtask

  task automatic wait_rel(input int prev, input string tag);
    int k = 0;
    while (n_rel == prev && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(tag, n_rel, prev + 1);
  endtask

  task automatic wait_col(input logic [3:0] pat, input bit equal, input string tag);
    int k = 0;
    while (((col_out == pat) != equal) && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk(tag, k < 64, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, prevr, c, m;
    rst  = 1'b1;
    keys = '0;
    repeat (2) @(negedge clk);
    chk("rst_col", col_out, 4'hE);
    chk("rst_outs", {key_valid, key_held, key_release, key_code}, 0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("rotate", col_out, col_pat((i / CLK_DIV) % 4));
    end
    chk("idle_outs", {key_valid, key_held, key_release}, 0);
    chk("idle_cnt", n_valid + n_rel, 0);

    // Row 2 on column 1 held from reset release.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    keys = keys_for(4'b0100, 1);
    rst  = 1'b0;
    prev = n_valid;
    wait_valid(prev, "press_seen");
    chk("press_code", key_code, exp_code(4'b0100, 1));
    chk("press_lat", valid_cyc, exp_accept_cyc(1));
    chk("press_held", key_held, 1);
    chk("press_col", col_out, 4'b1101);
    repeat (40) @(negedge clk);
    chk("no_repeat", n_valid, prev + 1);
    chk("frozen_col", col_out, 4'b1101);

    prevr = n_rel;
    keys  = '0;
    repeat (CLK_DIV) @(negedge clk);
    keys = keys_for(4'b0100, 1);
    repeat (6 * CLK_DIV) @(negedge clk);
    chk("glitch_rel", n_rel, prevr);
    chk("glitch_held", key_held, 1);

    keys = '0;
    wait_rel(prevr, "release_seen");
    chk("release_held", key_held, 0);
    repeat (CLK_DIV) @(negedge clk);
    chk("resume_col", col_out, 4'b1011);

    // Bounce: row 0 on column 3 visible for a single sampling tick.
    prev = n_valid;
    wait_col(4'b0111, 1'b0, "bounce_sync_a");
    wait_col(4'b0111, 1'b1, "bounce_sync_b");
    keys = keys_for(4'b0001, 3);
    repeat (CLK_DIV) @(negedge clk);
    keys = '0;
    repeat (CLK_DIV) @(negedge clk);
    chk("bounce_col_hold", col_out, 4'b0111);
    repeat (CLK_DIV) @(negedge clk);
    chk("bounce_col_next", col_out, 4'b1110);
    repeat (40) @(negedge clk);
    chk("bounce_no_valid", n_valid, prev);

    // Rows 1 and 3 on column 0, then an extra row-0 key while held.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    keys = keys_for(4'b1010, 0);
    rst  = 1'b0;
    prev = n_valid;
    wait_valid(prev, "multi_seen");
    chk("multi_code", key_code, exp_code(4'b1010, 0));
    chk("multi_lat", valid_cyc, exp_accept_cyc(0));
    keys = keys | keys_for(4'b0001, 0);
    repeat (40) @(negedge clk);
    chk("second_key", n_valid, prev + 1);
    chk("second_code", key_code, 4);

    // Reset while confirming a press, then while a key is held.
    rst = 1'b1;
    keys = '0;
    repeat (2) @(negedge clk);
    keys = keys_for(4'b0100, 1);
    rst  = 1'b0;
    repeat (10) @(negedge clk);
    prev = n_valid;
    rst  = 1'b1;
    @(negedge clk);
    chk("rst_pdb_col", col_out, 4'hE);
    chk("rst_pdb_outs", {key_valid, key_held}, 0);
    repeat (3) @(negedge clk);
    chk("rst_pdb_pulse", n_valid, prev);
    rst = 1'b0;
    wait_valid(prev, "rst_pdb_again");
    prev  = n_valid;
    prevr = n_rel;
    rst   = 1'b1;
    @(negedge clk);
    chk("rst_pr_col", col_out, 4'hE);
    chk("rst_pr_outs", {key_valid, key_held, key_release, key_code}, 0);
    keys = '0;
    rst  = 1'b0;
    repeat (8 * CLK_DIV) @(negedge clk);
    chk("rst_pr_pulses", n_valid + n_rel, prev + prevr);

    // Randomized single-column presses with optional release glitch.
    for (int it = 0; it < 12; it++) begin
      c = $urandom_range(0, 3);
      m = $urandom_range(1, 15);
      repeat ($urandom_range(0, 15)) @(negedge clk);
      prev = n_valid;
      keys = keys_for(m, c);
      wait_valid(prev, "rnd_seen");
      chk("rnd_code", key_code, exp_code(m, c));
      chk("rnd_col", col_out, col_pat(c));
      chk("rnd_held", key_held, 1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      prevr = n_rel;
      if ($urandom_range(0, 1) == 1) begin
        keys = '0;
        repeat (CLK_DIV) @(negedge clk);
        keys = keys_for(m, c);
        repeat (4 * CLK_DIV) @(negedge clk);
        chk("rnd_glitch", n_rel, prevr);
      end
      keys = '0;
      wait_rel(prevr, "rnd_release");
      chk("rnd_unheld", key_held, 0);
      chk("rnd_valid_cnt", n_valid, prev + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
